// File: rtl/gpio_in_if.sv
// Bus-side signals of the GPIO input peripheral: strobes, acknowledges, address and data.
interface gpio_in_if #(
    parameter int size_addr = 0
) ();
    logic                 read;
    logic                 write;
    logic                 ready_r;
    logic                 ready_w;
    logic [size_addr+1:0] address;
    logic [15:0]          data_in;
    logic [15:0]          data_out;

    modport master (
        output read, write, address, data_in,
        input  ready_r, ready_w, data_out
    );

    modport slave (
        input  read, write, address, data_in,
        output ready_r, ready_w, data_out
    );
endinterface

// File: rtl/gpio_in.sv
// Synchronized GPIO inputs with sticky W1C edge flags and a maskable registered irq.
// Acks one cycle after each strobe, no wait states; data_out holds the last read until the next read.
module gpio_in #(
    parameter int size_addr   = 0,
    parameter int size        = 1,
    parameter int sync_stages = 2
) (
    input  logic              clk,
    input  logic              reset,
    gpio_in_if.slave          bus,
    input  logic [size*16-1:0] port_in,
    output logic              irq
);
    logic [15:0] sync_q   [size][sync_stages];
    logic [15:0] prev     [size];
    logic [15:0] rise     [size];
    logic [15:0] fall     [size];
    logic [15:0] mask     [size];
    logic [15:0] clr_rise [size];
    logic [15:0] clr_fall [size];
    logic        wr_mask  [size];
    logic [15:0] rd_val;
    logic [15:0] buffer;
    logic [31:0] port_idx;
    logic        irq_next;

    // A single-port build has no index bits at all, so the index is tied off.
    generate
        if (size_addr == 0) begin : g_single
            assign port_idx = '0;
        end else begin : g_multi
            assign port_idx = 32'(bus.address[size_addr+1:2]);
        end
    endgenerate

    always_comb begin
        rd_val   = '0;
        irq_next = 1'b0;
        for (int p = 0; p < size; p++) begin
            clr_rise[p] = '0;
            clr_fall[p] = '0;
            wr_mask[p]  = 1'b0;
            irq_next    = irq_next | (|((rise[p] | fall[p]) & mask[p]));
            if (port_idx == 32'(p)) begin
                if (bus.write) begin
                    case (bus.address[1:0])
                        2'd1:    clr_rise[p] = bus.data_in;
                        2'd2:    clr_fall[p] = bus.data_in;
                        2'd3:    wr_mask[p]  = 1'b1;
                        default: ;
                    endcase
                end
                case (bus.address[1:0])
                    2'd0:    rd_val = sync_q[p][sync_stages-1];
                    2'd1:    rd_val = rise[p];
                    2'd2:    rd_val = fall[p];
                    default: rd_val = mask[p];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < size; p++) begin
                for (int k = 0; k < sync_stages; k++) begin
                    sync_q[p][k] <= '0;
                end
                prev[p] <= '0;
                rise[p] <= '0;
                fall[p] <= '0;
                mask[p] <= '0;
            end
            buffer      <= '0;
            bus.ready_r <= 1'b0;
            bus.ready_w <= 1'b0;
            irq         <= 1'b0;
        end else begin
            for (int p = 0; p < size; p++) begin
                sync_q[p][0] <= port_in[16*p +: 16];
                for (int k = 1; k < sync_stages; k++) begin
                    sync_q[p][k] <= sync_q[p][k-1];
                end
                prev[p] <= sync_q[p][sync_stages-1];
                // Clear first, then OR the new edge in, so a fresh edge beats a same-cycle W1C.
                rise[p] <= (rise[p] & ~clr_rise[p]) | (sync_q[p][sync_stages-1] & ~prev[p]);
                fall[p] <= (fall[p] & ~clr_fall[p]) | (~sync_q[p][sync_stages-1] & prev[p]);
                if (wr_mask[p]) begin
                    mask[p] <= bus.data_in;
                end
            end
            if (bus.read) begin
                buffer <= rd_val;
            end
            bus.ready_r <= bus.read;
            bus.ready_w <= bus.write;
            irq         <= irq_next;
        end
    end

    assign bus.data_out = buffer;
endmodule
